// File: rtl/wb_btn_ctrl_if.sv
// Wishbone classic bus bundle for the push-button slot.
// dat_w carries master-to-slave write data, dat_r slave-to-master read data.
interface wb_btn_ctrl_if;
    logic [31:0] adr;
    logic [31:0] dat_w;
    logic [31:0] dat_r;
    logic [3:0]  sel;
    logic        we;
    logic        cyc;
    logic        stb;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic        ack;
    logic        err;
    logic        rty;

    modport master (
        output adr, dat_w, sel, we, cyc, stb, cti, bte,
        input  dat_r, ack, err, rty
    );

    modport slave (
        input  adr, dat_w, sel, we, cyc, stb, cti, bte,
        output dat_r, ack, err, rty
    );
endinterface

// File: rtl/wb_btn_ctrl.sv
// Wishbone push-button controller: synchronise, debounce, latch press/release events
// and raise a level interrupt. Every bus access completes in two clocks.
module wb_btn_ctrl #(
    parameter int unsigned NUM_BTN         = 5,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    wb_btn_ctrl_if.slave       bus,
    input  logic [NUM_BTN-1:0] btn_i,
    output logic               irq_o
);

    localparam logic [3:0]       AdrState = 4'h0;
    localparam logic [3:0]       AdrRaw   = 4'h1;
    localparam logic [3:0]       AdrEvent = 4'h2;
    localparam logic [3:0]       AdrIe    = 4'h3;
    localparam logic [3:0]       AdrCtrl  = 4'h4;
    localparam logic [CNT_W-1:0] CntMax   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);

    typedef enum logic {StIdle, StAck} state_e;

    state_e state_q, state_d;

    logic [NUM_BTN-1:0] sync1_q, sync_q;
    logic [NUM_BTN-1:0] stable_q, stable_d;
    logic [CNT_W-1:0]   cnt_q [NUM_BTN];
    logic [CNT_W-1:0]   cnt_d [NUM_BTN];
    logic [NUM_BTN-1:0] event_q, event_d;
    logic [NUM_BTN-1:0] ie_q, ie_d;
    logic               ctrl_q, ctrl_d;
    logic               irq_q;
    logic [31:0]        rdat_q, rdat_d;

    logic [3:0]         reg_sel;
    logic               req;
    logic               wr;
    logic [31:0]        lane_mask;
    logic [31:0]        wdat_m;
    logic [31:0]        rdata;
    logic [NUM_BTN-1:0] ev_set;
    logic [NUM_BTN-1:0] ev_clr;

    // ---------------------------------------------------------------------------------------
    // Input synchroniser and per-button debounce counters
    // ---------------------------------------------------------------------------------------
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            sync1_q <= '0;
            sync_q  <= '0;
        end else begin
            sync1_q <= btn_i;
            sync_q  <= sync1_q;
        end
    end

    // A differing level must survive CntMax+1 consecutive clocks before it is accepted.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < NUM_BTN; i++) begin
            cnt_d[i] = '0;
            if (sync_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CntMax) begin
                    stable_d[i] = sync_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CntOne;
                end
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            stable_q <= '0;
            for (int i = 0; i < NUM_BTN; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            stable_q <= stable_d;
            for (int i = 0; i < NUM_BTN; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // ---------------------------------------------------------------------------------------
    // Bus decode
    // ---------------------------------------------------------------------------------------
    assign reg_sel = bus.adr[5:2];
    assign req     = bus.cyc & bus.stb & ~bus.ack;
    assign wr      = req & bus.we;

    always_comb begin
        lane_mask = '0;
        for (int k = 0; k < 4; k++) begin
            lane_mask[8*k +: 8] = {8{bus.sel[k]}};
        end
    end

    assign wdat_m = bus.dat_w & lane_mask;

    // ---------------------------------------------------------------------------------------
    // Event, enable and control registers
    // ---------------------------------------------------------------------------------------
    always_comb begin
        ev_set = (stable_d & ~stable_q) | ((~stable_d & stable_q) & {NUM_BTN{ctrl_q}});
        ev_clr = (wr && reg_sel == AdrEvent) ? wdat_m[NUM_BTN-1:0] : '0;
        // Hardware set is applied after the clear so a coincident event is never lost.
        event_d = (event_q & ~ev_clr) | ev_set;

        ie_d = ie_q;
        if (wr && reg_sel == AdrIe) begin
            ie_d = (ie_q & ~lane_mask[NUM_BTN-1:0]) | wdat_m[NUM_BTN-1:0];
        end

        ctrl_d = ctrl_q;
        if (wr && reg_sel == AdrCtrl && bus.sel[0]) begin
            ctrl_d = bus.dat_w[0];
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            event_q <= '0;
            ie_q    <= '0;
            ctrl_q  <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            event_q <= event_d;
            ie_q    <= ie_d;
            ctrl_q  <= ctrl_d;
            irq_q   <= |(event_q & ie_q);
        end
    end

    assign irq_o = irq_q;

    // ---------------------------------------------------------------------------------------
    // Read mux and acknowledge sequencing
    // ---------------------------------------------------------------------------------------
    always_comb begin
        rdata = '0;
        case (reg_sel)
            AdrState: rdata[NUM_BTN-1:0] = stable_q;
            AdrRaw:   rdata[NUM_BTN-1:0] = sync_q;
            AdrEvent: rdata[NUM_BTN-1:0] = event_q;
            AdrIe:    rdata[NUM_BTN-1:0] = ie_q;
            AdrCtrl:  rdata[0]           = ctrl_q;
            default:  rdata              = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        rdat_d  = '0;
        case (state_q)
            StIdle: begin
                if (req) begin
                    state_d = StAck;
                    if (!bus.we) begin
                        rdat_d = rdata;
                    end
                end
            end
            StAck:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= StIdle;
            rdat_q  <= '0;
        end else begin
            state_q <= state_d;
            rdat_q  <= rdat_d;
        end
    end

    assign bus.ack   = (state_q == StAck);
    assign bus.dat_r = bus.ack ? rdat_q : '0;
    assign bus.err   = 1'b0;
    assign bus.rty   = 1'b0;

    // Burst hints, undecoded address bits and masked-off data bits are intentionally ignored.
    logic unused_bus;
    assign unused_bus = ^{bus.cti, bus.bte, bus.adr[31:6], bus.adr[1:0], wdat_m};

endmodule

// File: tb/tb_wb_btn_ctrl.sv
// Directed self-checking bench for wb_btn_ctrl with NUM_BTN=5 and DEBOUNCE_CYCLES=4.
module tb_wb_btn_ctrl;

    logic       clk;
    logic       rst;
    logic [4:0] btn;
    logic       irq;
    int         tests;
    int         fails;

    wb_btn_ctrl_if bus ();

    wb_btn_ctrl #(
        .NUM_BTN        (5),
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (3)
    ) dut (
        .wb_clk_i(clk),
        .wb_rst_i(rst),
        .bus     (bus),
        .btn_i   (btn),
        .irq_o   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wb_read(input logic [31:0] a, output logic [31:0] d,
                           output logic ack_hi, output logic ack_lo, output logic [31:0] d_lo);
        bus.adr = a;
        bus.we  = 1'b0;
        bus.sel = 4'hF;
        bus.cyc = 1'b1;
        bus.stb = 1'b1;
        tick(1);
        ack_hi  = bus.ack;
        d       = bus.dat_r;
        bus.cyc = 1'b0;
        bus.stb = 1'b0;
        tick(1);
        ack_lo  = bus.ack;
        d_lo    = bus.dat_r;
    endtask

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic ack_hi, output logic ack_lo,
                            output logic irq_a, output logic irq_b);
        bus.adr   = a;
        bus.dat_w = d;
        bus.sel   = s;
        bus.we    = 1'b1;
        bus.cyc   = 1'b1;
        bus.stb   = 1'b1;
        tick(1);
        ack_hi  = bus.ack;
        irq_a   = irq;
        bus.cyc = 1'b0;
        bus.stb = 1'b0;
        bus.we  = 1'b0;
        tick(1);
        ack_lo = bus.ack;
        irq_b  = irq;
    endtask

    task automatic test_reset;
        logic [31:0] rd, dl;
        logic        ah, al;
        rst = 1'b1;
        tick(3);
        tests++;
        if (bus.ack !== 1'b0 || irq !== 1'b0 || bus.dat_r !== 32'h0) begin
            fails++;
            $display("FAIL reset_outputs: ack=%b irq=%b dat=%h, want 0 0 0",
                     bus.ack, irq, bus.dat_r);
        end
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wb_read(32'(i * 4), rd, ah, al, dl);
            tests++;
            if (rd !== 32'h0) begin
                fails++;
                $display("FAIL reset_read[%0d]: got %h want 0", i, rd);
            end
            tests++;
            if (ah !== 1'b1 || al !== 1'b0 || dl !== 32'h0) begin
                fails++;
                $display("FAIL ack_pulse[%0d]: ack %b,%b dat_lo %h want 1,0 and 0", i, ah, al, dl);
            end
            tests++;
            if (bus.err !== 1'b0 || bus.rty !== 1'b0) begin
                fails++;
                $display("FAIL err_rty[%0d]: err=%b rty=%b want 0 0", i, bus.err, bus.rty);
            end
        end
    endtask

    task automatic test_press_irq;
        logic [31:0] rd, dl;
        logic        ah, al, ia, ib;
        btn[2] = 1'b1;
        tick(5);
        wb_read(32'h00, rd, ah, al, dl);
        tests++;
        if (rd !== 32'h0) begin
            fails++;
            $display("FAIL press_early: STATE got %h want 0", rd);
        end
        wb_read(32'h00, rd, ah, al, dl);
        tests++;
        if (rd !== 32'h4) begin
            fails++;
            $display("FAIL press_state: STATE got %h want 4", rd);
        end
        wb_read(32'h08, rd, ah, al, dl);
        tests++;
        if (rd !== 32'h4) begin
            fails++;
            $display("FAIL press_event: EVENT got %h want 4", rd);
        end
        wb_write(32'h0C, 32'h4, 4'hF, ah, al, ia, ib);
        tests++;
        if (ia !== 1'b0 || ib !== 1'b1) begin
            fails++;
            $display("FAIL irq_rise: irq %b,%b want 0,1", ia, ib);
        end
        wb_write(32'h08, 32'h4, 4'hF, ah, al, ia, ib);
        tests++;
        if (ia !== 1'b1 || ib !== 1'b0) begin
            fails++;
            $display("FAIL irq_fall: irq %b,%b want 1,0", ia, ib);
        end
        wb_read(32'h08, rd, ah, al, dl);
        tests++;
        if (rd !== 32'h0) begin
            fails++;
            $display("FAIL w1c_event: EVENT got %h want 0", rd);
        end
    endtask

    task automatic test_glitch;
        logic [31:0] rd, raw, dl;
        logic        ah, al;
        fork
            begin
                btn[0] = 1'b1;
                tick(3);
                btn[0] = 1'b0;
            end
            begin
                tick(2);
                wb_read(32'h04, raw, ah, al, dl);
            end
        join
        tests++;
        if (raw !== 32'h5) begin
            fails++;
            $display("FAIL glitch_raw: RAW got %h want 5", raw);
        end
        tick(10);
        wb_read(32'h00, rd, ah, al, dl);
        tests++;
        if (rd !== 32'h4) begin
            fails++;
            $display("FAIL glitch_state: STATE got %h want 4", rd);
        end
        wb_read(32'h08, rd, ah, al, dl);
        tests++;
        if (rd !== 32'h0) begin
            fails++;
            $display("FAIL glitch_event: EVENT got %h want 0", rd);
        end
        wb_read(32'h04, rd, ah, al, dl);
        tests++;
        if (rd !== 32'h4) begin
            fails++;
            $display("FAIL glitch_raw_after: RAW got %h want 4", rd);
        end
    endtask

    task automatic test_release;
        logic [31:0] rd, dl;
        logic        ah, al, ia, ib;
        wb_write(32'h10, 32'hFFFF_FFFF, 4'hF, ah, al, ia, ib);
        wb_read(32'h10, rd, ah, al, dl);
        tests++;
        if (rd !== 32'h1) begin
            fails++;
            $display("FAIL ctrl_read: CTRL got %h want 1", rd);
        end
        btn[2] = 1'b0;
        tick(8);
        wb_read(32'h08, rd, ah, al, dl);
        tests++;
        if (rd !== 32'h4) begin
            fails++;
            $display("FAIL release_flagged: EVENT got %h want 4", rd);
        end
        wb_read(32'h00, rd, ah, al, dl);
        tests++;
        if (rd !== 32'h0) begin
            fails++;
            $display("FAIL release_state: STATE got %h want 0", rd);
        end
        wb_write(32'h08, 32'h4, 4'hF, ah, al, ia, ib);
        wb_write(32'h10, 32'h0, 4'hF, ah, al, ia, ib);
        btn[2] = 1'b1;
        tick(8);
        wb_read(32'h08, rd, ah, al, dl);
        tests++;
        if (rd !== 32'h4) begin
            fails++;
            $display("FAIL press_ctrl0: EVENT got %h want 4", rd);
        end
        wb_write(32'h08, 32'h4, 4'hF, ah, al, ia, ib);
        btn[2] = 1'b0;
        tick(8);
        wb_read(32'h08, rd, ah, al, dl);
        tests++;
        if (rd !== 32'h0) begin
            fails++;
            $display("FAIL release_unflagged: EVENT got %h want 0", rd);
        end
    endtask

    task automatic test_set_beats_clear;
        logic [31:0] rd, dl;
        logic        ah, al, ia, ib;
        btn[3] = 1'b1;
        tick(8);
        wb_read(32'h08, rd, ah, al, dl);
        tests++;
        if (rd !== 32'h8) begin
            fails++;
            $display("FAIL pending_bit3: EVENT got %h want 8", rd);
        end
        // The write below commits on the same edge that debounces btn[1].
        btn[1] = 1'b1;
        tick(5);
        wb_write(32'h08, 32'h0A, 4'hF, ah, al, ia, ib);
        wb_read(32'h08, rd, ah, al, dl);
        tests++;
        if (rd !== 32'h2) begin
            fails++;
            $display("FAIL set_beats_clear: EVENT got %h want 2", rd);
        end
    endtask

    task automatic test_lanes_and_reset;
        logic [31:0] rd, dl;
        logic        ah, al, ia, ib;
        wb_write(32'h0C, 32'hFFFF_FF00, 4'hF, ah, al, ia, ib);
        wb_read(32'h0C, rd, ah, al, dl);
        tests++;
        if (rd !== 32'h0) begin
            fails++;
            $display("FAIL ie_high_bits: IE got %h want 0", rd);
        end
        wb_write(32'h0C, 32'hFFFF_FFFF, 4'b0001, ah, al, ia, ib);
        wb_read(32'h0C, rd, ah, al, dl);
        tests++;
        if (rd !== 32'h1F) begin
            fails++;
            $display("FAIL ie_lane0: IE got %h want 1f", rd);
        end
        wb_write(32'h0C, 32'h0, 4'b0010, ah, al, ia, ib);
        wb_read(32'h0C, rd, ah, al, dl);
        tests++;
        if (rd !== 32'h1F) begin
            fails++;
            $display("FAIL ie_lane1_gated: IE got %h want 1f", rd);
        end
        wb_write(32'h14, 32'hFFFF_FFFF, 4'hF, ah, al, ia, ib);
        tests++;
        if (ah !== 1'b1 || al !== 1'b0) begin
            fails++;
            $display("FAIL unmapped_ack: ack %b,%b want 1,0", ah, al);
        end
        wb_read(32'h14, rd, ah, al, dl);
        tests++;
        if (rd !== 32'h0) begin
            fails++;
            $display("FAIL unmapped_14: got %h want 0", rd);
        end
        wb_read(32'h3C, rd, ah, al, dl);
        tests++;
        if (rd !== 32'h0 || ah !== 1'b1) begin
            fails++;
            $display("FAIL unmapped_3c: got %h ack %b want 0 ack 1", rd, ah);
        end
        wb_write(32'h10, 32'h1, 4'hF, ah, al, ia, ib);
        btn = '0;
        tick(8);
        wb_read(32'h08, rd, ah, al, dl);
        tests++;
        if (rd !== 32'h0A) begin
            fails++;
            $display("FAIL release_events: EVENT got %h want a", rd);
        end
        tests++;
        if (irq !== 1'b1) begin
            fails++;
            $display("FAIL irq_before_reset: got %b want 1", irq);
        end
        // Reset coincides with a write request: no ack, nothing kept.
        bus.adr   = 32'h10;
        bus.dat_w = 32'h1;
        bus.sel   = 4'hF;
        bus.we    = 1'b1;
        bus.cyc   = 1'b1;
        bus.stb   = 1'b1;
        rst       = 1'b1;
        tick(1);
        tests++;
        if (bus.ack !== 1'b0 || irq !== 1'b0) begin
            fails++;
            $display("FAIL reset_in_req: ack=%b irq=%b want 0 0", bus.ack, irq);
        end
        rst     = 1'b0;
        bus.cyc = 1'b0;
        bus.stb = 1'b0;
        bus.we  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wb_read(32'(i * 4), rd, ah, al, dl);
            tests++;
            if (rd !== 32'h0) begin
                fails++;
                $display("FAIL post_reset[%0d]: got %h want 0", i, rd);
            end
        end
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        rst       = 1'b1;
        btn       = '0;
        bus.adr   = '0;
        bus.dat_w = '0;
        bus.sel   = '0;
        bus.we    = 1'b0;
        bus.cyc   = 1'b0;
        bus.stb   = 1'b0;
        bus.cti   = '0;
        bus.bte   = '0;
        test_reset();
        test_press_irq();
        test_glitch();
        test_release();
        test_set_beats_clear();
        test_lanes_and_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
